// File: rtl/jk_pkg.sv
// Shared definitions for the JK bank scheduler: op encoding, FSM states and the
// per-bit expected-result helper used by the optional check stage.
package jk_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_CLR  = 2'b01;
   localparam logic [1:0] OP_SET  = 2'b10;
   localparam logic [1:0] OP_TGL  = 2'b11;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      DRIVE = 2'd2,
      CHECK = 2'd3
   } jk_state_e;

   // Expected bank bit after one JK op: unmasked bits keep their previous value.
   function automatic logic jk_expect_bit(input logic [1:0] op, input logic m, input logic qp);
      logic f;
      case (op)
         OP_HOLD: f = qp;
         OP_CLR:  f = 1'b0;
         OP_SET:  f = 1'b1;
         default: f = ~qp;
      endcase
      return m ? f : qp;
   endfunction

endpackage

// File: rtl/jk_bank_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr_i+1 with wrap and returns a
// one-hot grant, its index and an any-grant flag (all combinational).
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_c,
   output logic [$clog2(N)-1:0] idx_c,
   output logic                 any_c
);

   localparam int unsigned IW = $clog2(N);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      cand  = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         cand = IW'((32'(ptr_i) + off) % N);
         if (!any_c && req_i[cand]) begin
            any_c       = 1'b1;
            gnt_c[cand] = 1'b1;
            idx_c       = cand;
         end
      end
   end

endmodule

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler sharing one JK flip-flop bank among NREQ requesters.
// Define JK_SCHED_CHECK_EN to add the CHECK state and sticky err comparison.
module jk_bank_scheduler
   import jk_pkg::*;
#(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_mask,
   output logic [NREQ-1:0]         req_ready,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic [WIDTH-1:0]        j_out,
   output logic [WIDTH-1:0]        k_out,
   output logic                    bank_rst_n,
   input  logic [WIDTH-1:0]        q_in,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   localparam int unsigned IW = $clog2(NREQ);

   jk_state_e        state_q;
   logic [IW-1:0]    ptr_q;
   logic [IW-1:0]    grant_q;
   logic [WIDTH-1:0] j_q;
   logic [WIDTH-1:0] k_q;
   logic             bank_rst_n_q;
   logic             busy_q;
   logic             done_q;

   logic [NREQ-1:0]  gnt_oh;
   logic [IW-1:0]    gnt_idx;
   logic             gnt_any;
   logic [1:0]       op_sel;
   logic [WIDTH-1:0] mask_sel;

   rr_arbiter #(.N(NREQ)) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_c (gnt_oh),
      .idx_c (gnt_idx),
      .any_c (gnt_any)
   );

   // Handshake is only offered while idle.
   assign req_ready = (state_q == IDLE) ? gnt_oh : '0;

   always_comb begin
      op_sel   = '0;
      mask_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_oh[i]) begin
            op_sel   = req_op[2*i +: 2];
            mask_sel = req_mask[WIDTH*i +: WIDTH];
         end
      end
   end

`ifdef JK_SCHED_CHECK_EN
   logic [1:0]       op_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] q_prev_q;
   logic [WIDTH-1:0] exp_c;
   logic             err_q;

   always_comb begin
      exp_c = '0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
         exp_c[b] = jk_expect_bit(op_q, mask_q[b], q_prev_q[b]);
      end
   end

   assign err = err_q;
`else
   logic unused_q;
   assign unused_q = ^q_in;
   assign err      = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= INIT;
         ptr_q        <= IW'(NREQ - 1);
         grant_q      <= '0;
         j_q          <= '0;
         k_q          <= '0;
         bank_rst_n_q <= 1'b0;
         busy_q       <= 1'b1;
         done_q       <= 1'b0;
`ifdef JK_SCHED_CHECK_EN
         op_q         <= '0;
         mask_q       <= '0;
         q_prev_q     <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         j_q    <= '0;
         k_q    <= '0;
         case (state_q)
            INIT: begin
               bank_rst_n_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= IDLE;
            end
            IDLE: begin
               if (gnt_any) begin
                  grant_q <= gnt_idx;
                  ptr_q   <= gnt_idx;
                  j_q     <= op_sel[1] ? mask_sel : '0;
                  k_q     <= op_sel[0] ? mask_sel : '0;
                  busy_q  <= 1'b1;
                  state_q <= DRIVE;
`ifdef JK_SCHED_CHECK_EN
                  op_q     <= op_sel;
                  mask_q   <= mask_sel;
                  q_prev_q <= q_in;
`else
                  done_q   <= 1'b1;
`endif
               end
            end
            DRIVE: begin
`ifdef JK_SCHED_CHECK_EN
               done_q  <= 1'b1;
               state_q <= CHECK;
`else
               busy_q  <= 1'b0;
               state_q <= IDLE;
`endif
            end
`ifdef JK_SCHED_CHECK_EN
            CHECK: begin
               if (q_in != exp_c) err_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
`endif
            default: begin
               busy_q  <= 1'b1;
               state_q <= INIT;
            end
         endcase
      end
   end

   assign grant_id   = grant_q;
   assign j_out      = j_q;
   assign k_out      = k_q;
   assign bank_rst_n = bank_rst_n_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Self-checking bench for jk_bank_scheduler with a behavioural JK bank model;
// expectations adapt to whether JK_SCHED_CHECK_EN is defined.
module tb_jk_bank_scheduler;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned WIDTH = 8;
`ifdef JK_SCHED_CHECK_EN
   localparam logic        CHK     = 1'b1;
   localparam int unsigned SPACING = 3;
`else
   localparam logic        CHK     = 1'b0;
   localparam int unsigned SPACING = 2;
`endif

   logic                    clk;
   logic                    reset;
   logic [NREQ-1:0]         req_valid;
   logic [2*NREQ-1:0]       req_op;
   logic [WIDTH*NREQ-1:0]   req_mask;
   logic [NREQ-1:0]         req_ready;
   logic [$clog2(NREQ)-1:0] grant_id;
   logic [WIDTH-1:0]        j_out;
   logic [WIDTH-1:0]        k_out;
   logic                    bank_rst_n;
   logic [WIDTH-1:0]        q_in;
   logic                    busy;
   logic                    done;
   logic                    err;

   logic [WIDTH-1:0]        bank_q;
   logic                    stuck;

   int checks = 0;
   int errors = 0;

   jk_bank_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_mask   (req_mask),
      .req_ready  (req_ready),
      .grant_id   (grant_id),
      .j_out      (j_out),
      .k_out      (k_out),
      .bank_rst_n (bank_rst_n),
      .q_in       (q_in),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // JK bank with synchronous active-low reset; stuck forces the feedback to zero.
   always @(posedge clk) begin
      if (!bank_rst_n) bank_q <= '0;
      else             bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
   end
   assign q_in = stuck ? '0 : bank_q;

   typedef struct {
      string      nm;
      int         rid;
      logic [1:0] op;
      logic [7:0] mask;
      logic [7:0] exp_j;
      logic [7:0] exp_k;
      logic [7:0] exp_q;
      logic       exp_err;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_slot();
      @(posedge clk);
      #1;
   endtask

   function automatic int idx_of(input logic [NREQ-1:0] oh);
      int r = -1;
      for (int i = 0; i < int'(NREQ); i++) if (oh[i]) r = i;
      return r;
   endfunction

   // One full operation from a single requester, checked cycle by cycle.
   task automatic do_op(input vec_t v);
      int n;
      int dones;
      drive_slot();
      req_valid = '0;
      req_op    = '0;
      req_mask  = '0;
      req_valid[v.rid]           = 1'b1;
      req_op[2*v.rid +: 2]       = v.op;
      req_mask[WIDTH*v.rid +: 8] = v.mask;
      @(negedge clk);
      chk({v.nm, "_ready"}, 32'(req_ready), 32'(1 << v.rid));
      chk({v.nm, "_idle_busy"}, 32'(busy), 32'd0);
      drive_slot();
      req_valid = '0;
      @(negedge clk);
      chk({v.nm, "_j"}, 32'(j_out), 32'(v.exp_j));
      chk({v.nm, "_k"}, 32'(k_out), 32'(v.exp_k));
      chk({v.nm, "_gid"}, 32'(grant_id), 32'(v.rid));
      chk({v.nm, "_drive_done"}, 32'(done), 32'(!CHK));
      chk({v.nm, "_drive_ready"}, 32'(req_ready), 32'd0);
      dones = int'(done);
      n = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         dones += int'(done);
         chk({v.nm, "_post_jk"}, 32'({j_out, k_out}), 32'd0);
      end
      chk({v.nm, "_extra_cycles"}, 32'(n), 32'(SPACING - 2));
      chk({v.nm, "_done_count"}, 32'(dones), 32'd1);
      chk({v.nm, "_idle_done"}, 32'(done), 32'd0);
      chk({v.nm, "_q"}, 32'(bank_q), 32'(v.exp_q));
      chk({v.nm, "_err"}, 32'(err), 32'(v.exp_err));
   endtask

   initial begin
      int   gcount;
      int   last;
      int   exp_seq [5];
      vec_t sv;

      exp_seq = '{0, 1, 2, 3, 0};
      tbl[0] = '{"set_f0",  0, 2'b10, 8'hF0, 8'hF0, 8'h00, 8'hF0, 1'b0};
      tbl[1] = '{"tgl_3c",  1, 2'b11, 8'h3C, 8'h3C, 8'h3C, 8'hCC, 1'b0};
      tbl[2] = '{"clr_c0",  2, 2'b01, 8'hC0, 8'h00, 8'hC0, 8'h0C, 1'b0};
      tbl[3] = '{"hold_ff", 3, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h0C, 1'b0};
      tbl[4] = '{"set_m0",  0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h0C, 1'b0};
      tbl[5] = '{"tgl_0f",  2, 2'b11, 8'h0F, 8'h0F, 8'h0F, 8'h03, 1'b0};
      tbl[6] = '{"set_81",  1, 2'b10, 8'h81, 8'h81, 8'h00, 8'h83, 1'b0};

      reset     = 1'b1;
      stuck     = 1'b0;
      req_valid = '1;
      req_op    = '0;
      req_mask  = '0;

      // Reset values, with requests already pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_jk", 32'({j_out, k_out}), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_bank_rst_n", 32'(bank_rst_n), 32'd0);

      drive_slot();
      reset = 1'b0;
      @(negedge clk);
      chk("init_ready", 32'(req_ready), 32'd0);
      chk("init_bank_rst_n", 32'(bank_rst_n), 32'd0);
      chk("init_busy", 32'(busy), 32'd1);

      // All requesters valid: strict rotation starting at requester 0.
      gcount = 0;
      last   = 0;
      for (int c = 0; c < 40 && gcount < 5; c++) begin
         @(negedge clk);
         chk("rr_ready_only_idle", 32'(busy && (req_ready != '0)), 32'd0);
         if (req_ready != '0) begin
            if (gcount == 0) begin
               chk("rr_first_cycle", 32'(c), 32'd0);
               chk("rr_bank_rst_n", 32'(bank_rst_n), 32'd1);
               chk("rr_bank_q0", 32'(bank_q), 32'd0);
            end else begin
               chk("rr_spacing", 32'(c - last), 32'(SPACING));
            end
            chk("rr_onehot", 32'($countones(req_ready)), 32'd1);
            chk("rr_grant", 32'(idx_of(req_ready)), 32'(exp_seq[gcount]));
            last = c;
            gcount++;
         end
      end
      chk("rr_count", 32'(gcount), 32'd5);
      drive_slot();
      req_valid = '0;
      for (int c = 0; c < 8 && busy; c++) @(negedge clk);
      @(negedge clk);
      chk("rr_drained", 32'(busy), 32'd0);
      chk("rr_bank_q", 32'(bank_q), 32'd0);

      foreach (tbl[i]) do_op(tbl[i]);

      // Feedback stuck at zero during a set: mismatch latches err.
      stuck = 1'b1;
      sv = '{"stuck_set", 3, 2'b10, 8'h01, 8'h01, 8'h00, 8'h83, CHK};
      do_op(sv);
      stuck = 1'b0;
      sv = '{"after_stuck", 0, 2'b00, 8'h00, 8'h00, 8'h00, 8'h83, CHK};
      do_op(sv);
      sv = '{"after_stuck2", 2, 2'b11, 8'h80, 8'h80, 8'h80, 8'h03, CHK};
      do_op(sv);

      // Reset asserted while driving the bank.
      drive_slot();
      req_valid = 4'b0100;
      req_op    = '0;
      req_mask  = '0;
      req_op[5:4]    = 2'b10;
      req_mask[23:16] = 8'hFF;
      @(negedge clk);
      chk("mid_ready", 32'(req_ready), 32'h4);
      drive_slot();
      req_valid = '1;
      @(negedge clk);
      chk("mid_drive_j", 32'(j_out), 32'hFF);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_jk", 32'({j_out, k_out}), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      chk("mid_rst_err", 32'(err), 32'd0);
      chk("mid_rst_gid", 32'(grant_id), 32'd0);
      chk("mid_rst_bank_rst_n", 32'(bank_rst_n), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      drive_slot();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_init_ready", 32'(req_ready), 32'd0);
      chk("mid_init_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("mid_idle_ready", 32'(req_ready), 32'h1);
      chk("mid_idle_done", 32'(done), 32'd0);
      chk("mid_bank_q", 32'(bank_q), 32'd0);
      drive_slot();
      req_valid = '0;
      for (int c = 0; c < 8 && busy; c++) @(negedge clk);
      @(negedge clk);
      chk("end_idle", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jk_bank_scheduler.md
# jk_bank_scheduler

Round-robin command scheduler that shares one WIDTH-bit bank of JK flip-flops among NREQ requesters. Each granted request applies one JK operation (hold/clear/set/toggle) to a masked subset of bank bits. The scheduler drives the bank's j/k vectors and its synchronous active-low bank reset, and reads the bank's q outputs back. An optional check stage compares the bank state against the expected result after each operation.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, bank width in bits

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_op  in  2*NREQ  per-requester op; requester i uses bits [2i+1:2i]
- req_mask  in  WIDTH*NREQ  per-requester bit mask; requester i uses bits [WIDTH*i +: WIDTH]
- req_ready  out  NREQ  one-hot accept strobe
- grant_id  out  $clog2(NREQ)  index of the last accepted requester
- j_out, k_out  out  WIDTH  drive of the bank's j and k inputs
- bank_rst_n  out  1  drive of the bank's synchronous active-low reset
- q_in  in  WIDTH  bank q feedback
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when an operation completes
- err  out  1  sticky mismatch flag (check build only)

## Operation
- Op encoding is {j,k}:
  - 00 = hold
  - 01 = clear
  - 10 = set
  - 11 = toggle
- The FSM has four states: INIT, IDLE, DRIVE, CHECK.
- **INIT**
  - Entered on reset.
  - bank_rst_n = 0 for the first clock edge after reset deasserts; then go to IDLE.
  - No request is accepted in INIT.
- **IDLE**
  - If any req_valid is high, the round-robin arbiter picks requester g, searching upward from ptr+1 with wrap.
  - req_ready[g] = 1 combinationally in that cycle; that is the handshake.
  - At the edge, register op, mask, snapshot q_in into q_prev, set grant_id = g and ptr = g, then go to DRIVE.
  - With no valid request, stay in IDLE.
- **DRIVE**
  - j_out = op[1] ? mask : 0.
  - k_out = op[0] ? mask : 0.
  - Held for exactly one cycle; the bank updates at the edge that ends DRIVE.
- **CHECK**
  - expected = (q_prev & ~mask) | (mask & f(q_prev)), where f is:
    - hold: q_prev
    - clear: 0
    - set: all ones
    - toggle: ~q_prev
  - If q_in != expected, set err (sticky until reset).
  - Pulse done; return to IDLE.
- j_out/k_out are 0 in every state except DRIVE.
- A requester that drops req_valid before it is granted loses nothing; no state is kept per requester.
- A mask of 0 is legal: j_out/k_out stay 0 and the check passes.
- Simultaneous requests from all NREQ requesters are served in strict rotation; none is starved beyond NREQ-1 operations.

## Timing
- Reset values:
  - state = INIT
  - j_out = k_out = 0
  - req_ready = 0
  - done = 0, err = 0, busy = 1
  - grant_id = 0
  - ptr = NREQ-1, so requester 0 wins first
  - bank_rst_n = 0
- Latency and throughput:
  - Check build: accept (cycle 0), DRIVE (cycle 1), CHECK with done (cycle 2), next accept possible at cycle 3. One op per 3 cycles.
  - No-check build: done pulses in the DRIVE cycle. One op per 2 cycles.
- Reset asserted mid-operation: all outputs go to reset values immediately. The latched op is discarded, no done is issued, and the FSM restarts in INIT.
- req_ready is never high outside IDLE and is never high for more than one requester.

## Configuration
- JK_SCHED_CHECK_EN defined:
  - CHECK state and q_prev register are present.
  - err is driven as described.
- JK_SCHED_CHECK_EN undefined:
  - No CHECK state; DRIVE returns directly to IDLE with done asserted in DRIVE.
  - q_prev is removed and err is tied to 0.
  - q_in is unused apart from the snapshot logic, which is also removed.

## Structure
- Shared package jk_pkg holds:
  - op localparams OP_HOLD, OP_CLR, OP_SET, OP_TGL
  - the FSM state encoding INIT/IDLE/DRIVE/CHECK
  - a function computing the expected value from op, mask and q_prev
- One sub-module, rr_arbiter (parameter N), takes req vector and ptr and returns a one-hot grant plus its index.

## Test plan
- Reset release with NREQ=4, WIDTH=8 -> bank_rst_n low for 1 edge, then IDLE; all outputs at reset values; bank q = 8'h00.
- Requester 0 sets mask 8'hF0 -> j_out = 8'hF0, k_out = 8'h00 for exactly one cycle; q = 8'hF0; done on cycle 2; err = 0.
- Then requester 1 toggles mask 8'h3C -> j_out = k_out = 8'h3C; q = 8'hCC; done; err = 0.
- All four requesters valid continuously -> grants 0,1,2,3,0 in that order, one req_ready per accept, spacing 3 cycles.
- Bank q_in forced stuck at 8'h00 during a set of mask 8'h01 -> err rises in CHECK and stays high through later passing ops.
- Reset asserted during DRIVE -> j_out/k_out = 0 immediately, no done, INIT re-entered, next grant goes to requester 0.
